mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the MEM-stage data path, next to l1d. It consumes store traffic (address, input_data, mem_write) and answers status loads. Written bytes are queued in a small FIFO and serialized 8N1, LSB first, on a single tx pin. It is the first real peripheral on the bus; the memory controller muxes its read data in whenever hit is asserted.

Parameters:
CLKS_PER_BIT, 234, clock cycles per UART bit (27 MHz / 115200); minimum 2
FIFO_DEPTH, 4, byte entries in the transmit FIFO; power of two, minimum 2
BASE_ADDRESS, 32'h0000_2000, byte address of DATA register; STATUS at BASE_ADDRESS+4

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
address  input  32  byte address from MEM stage (mem_result)
input_data  input  32  store data; bits [7:0] used
mem_write  input  1  store strobe, sampled on posedge clock
mem_read  input  1  load strobe
output_data  output  32  load data, combinational
hit  output  1  address matches DATA or STATUS (combinational)
tx  output  1  serial line, idle high

Behaviour:
- Reset (async): tx=1, FSM=IDLE, FIFO empty, counters 0, overflow=0. Outputs from registers are valid immediately on reset.
- Address decode: hit=1 iff address[31:2] equals BASE_ADDRESS[31:2] or (BASE_ADDRESS+4)[31:2]. address[1:0] is ignored.
- DATA write (hit, DATA, mem_write): on posedge, push input_data[7:0].
  - Accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set (sticky).
- STATUS write: ignored. mem_write with hit=0: ignored.
- output_data when mem_read & STATUS selected:
  - bit0 busy (FSM != IDLE)
  - bit1 full
  - bit2 empty
  - bit3 overflow
  - bits[7:4] count, zero-extended
  - all upper bits 0
- output_data is 0 in every other case, including DATA reads.
- Overflow clears on the posedge of a cycle with mem_read & STATUS. A simultaneous new overflow wins (stays 1).
- FSM states: IDLE, START, DATA, STOP. baud_cnt counts 0..CLKS_PER_BIT-1; bit_idx counts 0..7.
  - IDLE: tx=1. If FIFO is non-empty, pop the head into shift_reg and go to START (baud_cnt=0). A byte pushed at cycle N pops at N+1 at the earliest.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
  - DATA: tx=shift_reg[bit_idx] for CLKS_PER_BIT cycles each. After bit_idx=7 expires, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE. Back-to-back frames cost one IDLE cycle (frame period 10*CLKS_PER_BIT+1).
- tx is driven from a register (glitch-free). The first START low appears the cycle after the pop.
- FIFO: circular, rd/wr pointers of width log2(FIFO_DEPTH) that wrap, count of width log2(FIFO_DEPTH)+1. Push and pop in the same cycle leave count unchanged.
- Reset mid-frame: tx returns high asynchronously and the queued bytes are discarded.
- No stall output. Stores never back-pressure the pipeline; software polls STATUS.full.

Decomposition:
- Shared defines file (existing `define style) gets: `UART_REG_DATA (0), `UART_REG_STATUS (4), `UART_STATE_IDLE/START/DATA/STOP (2-bit encodings), and STATUS bit indices `UART_ST_BUSY, `UART_ST_FULL, `UART_ST_EMPTY, `UART_ST_OVF.
- One sub-module: uart_tx_fifo (parameter DEPTH). Ports: clock, reset, push, push_data[7:0], pop, pop_data[7:0], full, empty, count.
- The FSM, decode and STATUS mux stay in mmio_uart_tx.

Test Plan:
- Bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4.
- Reset, then idle 20 cycles -> tx=1 throughout; STATUS read returns 32'h0000_0004.
- Store 32'hFFFF_FF55 to 0x2000 -> tx low 4 cycles, then bits 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles. Total 40 cycles, starting the cycle after the pop. busy=1 during the frame.
- Four consecutive stores 0x41..0x44 -> frames A,B,C,D emitted in order, 41-cycle frame period. STATUS count goes 1,2,3 (first byte popped immediately) and never sets overflow.
- Six stores in consecutive cycles while idle -> the first pops and four queue. The sixth is dropped: STATUS = full=1, overflow=1, count=4 (32'h4B). The next STATUS read returns overflow=1, the read after that returns overflow=0.
- Assert reset mid-DATA-bit of frame 0x0F with 2 bytes queued -> tx=1 within the reset cycle (async). After release, STATUS=32'h04 and no further frames appear.
- Load from 0x2008 and store to 0x1FFC -> hit=0, output_data=0, FIFO unchanged, tx stays idle.

Source files
------------

// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter.
// Register offsets, FSM encodings and STATUS bit positions.
package mmio_uart_tx_pkg;

    localparam logic [31:0] UART_REG_DATA   = 32'd0;
    localparam logic [31:0] UART_REG_STATUS = 32'd4;

    localparam logic [1:0] UART_STATE_IDLE  = 2'd0;
    localparam logic [1:0] UART_STATE_START = 2'd1;
    localparam logic [1:0] UART_STATE_DATA  = 2'd2;
    localparam logic [1:0] UART_STATE_STOP  = 2'd3;

    localparam int UART_ST_BUSY  = 0;
    localparam int UART_ST_FULL  = 1;
    localparam int UART_ST_EMPTY = 2;
    localparam int UART_ST_OVF   = 3;

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding the UART serializer.
// Pointers wrap naturally; DEPTH must be a power of two.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  mem_d [DEPTH];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic do_push, do_pop;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == (AW+1)'(DEPTH));
    assign count    = cnt_q;
    assign pop_data = mem_q[rd_q];

    // A full FIFO still accepts a byte when the head leaves this cycle.
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// MEM-stage UART transmitter: DATA/STATUS registers, FIFO, 8N1 serializer.
// Stores never stall; software polls STATUS.full before writing.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 234,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_2000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] input_data,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic [31:0] output_data,
    output logic        hit,
    output logic        tx
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] DATA_ADDR   = BASE_ADDRESS + UART_REG_DATA;
    localparam logic [31:0] STATUS_ADDR = BASE_ADDRESS + UART_REG_STATUS;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic          sel_data, sel_status;
    logic          push_req, pop;
    logic          full, empty;
    logic [CW-1:0] count;
    logic [7:0]    pop_data;
    logic [31:0]   status_word;

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          ovf_q, ovf_d;

    logic unused_bits;
    assign unused_bits = ^{input_data[31:8], address[1:0]};

    assign sel_data   = (address[31:2] == DATA_ADDR[31:2]);
    assign sel_status = (address[31:2] == STATUS_ADDR[31:2]);
    assign hit        = sel_data | sel_status;
    assign push_req   = mem_write & sel_data;
    assign tx         = tx_q;

    uart_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_req),
        .push_data (input_data[7:0]),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // STATUS word and load data mux; everything else reads as zero.
    always_comb begin
        status_word                = '0;
        status_word[UART_ST_BUSY]  = (state_q != UART_STATE_IDLE);
        status_word[UART_ST_FULL]  = full;
        status_word[UART_ST_EMPTY] = empty;
        status_word[UART_ST_OVF]   = ovf_q;
        status_word[7:4]           = 4'(count);
        output_data = (mem_read & sel_status) ? status_word : '0;
    end

    // Sticky overflow: a fresh drop beats the clear-on-read.
    always_comb begin
        ovf_d = ovf_q;
        if (mem_read & sel_status) begin
            ovf_d = 1'b0;
        end
        if (push_req & full & ~pop) begin
            ovf_d = 1'b1;
        end
    end

    // Serializer; tx_d is the level for the next cycle.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        unique case (state_q)
            UART_STATE_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = pop_data;
                    baud_d  = '0;
                    tx_d    = 1'b0;
                    state_d = UART_STATE_START;
                end
            end
            UART_STATE_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = UART_STATE_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            UART_STATE_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = UART_STATE_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            UART_STATE_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = UART_STATE_IDLE;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = UART_STATE_IDLE;
            end
        endcase
    end

    // Serializer and status state; tx idles high out of reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= UART_STATE_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized bench for mmio_uart_tx against a frame-timing model.
// The model schedules each accepted byte as a 10-bit frame on a timeline.
module tb_mmio_uart_tx;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_2000;
    localparam int          FLEN  = 10 * CPB;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] input_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] output_data;
    logic        hit;
    logic        tx;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int chk_from = 0;
    logic txlog [0:8191];

    int         m_start [$];
    logic [7:0] m_byte  [$];
    logic       m_ovf = 1'b0;

    always #5 clock = ~clock;

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .BASE_ADDRESS (BASE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .address     (address),
        .input_data  (input_data),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .output_data (output_data),
        .hit         (hit),
        .tx          (tx)
    );

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        txlog[cyc] = tx;
    endtask

    // Frame starts the edge after the push, or one idle cycle after the
    // previous frame; a byte is dropped when the queue is full and no
    // byte leaves on that same edge.
    task automatic model_push(input logic [7:0] b, input int p);
        int  pend = 0;
        bit  popnow = 0;
        int  st;
        foreach (m_start[i]) begin
            if (m_start[i] >= p) pend++;
            if (m_start[i] == p) popnow = 1;
        end
        if (pend < DEPTH || popnow) begin
            st = p + 1;
            if (m_start.size() > 0 && m_start[$] + FLEN + 1 > st)
                st = m_start[$] + FLEN + 1;
            m_start.push_back(st);
            m_byte.push_back(b);
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic model_clear();
        m_start.delete();
        m_byte.delete();
        m_ovf = 1'b0;
    endtask

    function automatic logic exp_tx(input int t);
        foreach (m_start[i]) begin
            if (t >= m_start[i] && t < m_start[i] + FLEN) begin
                int slot = (t - m_start[i]) / CPB;
                logic [7:0] b = m_byte[i];
                if (slot == 0) return 1'b0;
                if (slot == 9) return 1'b1;
                return b[slot-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_status(input int t);
        int c = 0;
        logic bsy = 1'b0;
        logic [31:0] r = '0;
        foreach (m_start[i]) begin
            if (m_start[i] > t) c++;
            if (m_start[i] <= t && t < m_start[i] + FLEN) bsy = 1'b1;
        end
        r[0]   = bsy;
        r[1]   = (c == DEPTH);
        r[2]   = (c == 0);
        r[3]   = m_ovf;
        r[7:4] = c[3:0];
        return r;
    endfunction

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        address    = a;
        input_data = d;
        mem_write  = 1'b1;
        tick();
        mem_write  = 1'b0;
        if (a[31:2] == BASE[31:2]) model_push(d[7:0], cyc);
    endtask

    task automatic read_status(output logic [31:0] v);
        address  = BASE + 32'd4;
        mem_read = 1'b1;
        #1;
        v = output_data;
        tick();
        mem_read = 1'b0;
        m_ovf    = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1;
        #1;
        n_checks++;
        if (tx !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tx got %b want 1", tx);
        end
        repeat (3) tick();
        reset = 1'b0;
        chk_from = cyc + 1;
        repeat (20) tick();
        for (int t = chk_from; t <= cyc; t++) begin
            n_checks++;
            if (txlog[t] !== 1'b1) begin
                n_fail++;
                $display("FAIL idle_tx t=%0d got %b want 1", t, txlog[t]);
            end
        end
        chk_from = cyc + 1;
        read_status(v);
        n_checks++;
        if (v !== 32'h0000_0004) begin
            n_fail++;
            $display("FAIL reset_status got %h want 00000004", v);
        end
    endtask

    task automatic test_single();
        logic [31:0] v, e;
        store(BASE, 32'hFFFF_FF55);
        repeat (10) tick();
        e = exp_status(cyc);
        read_status(v);
        n_checks++;
        if (v !== e || v[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy got %h want %h", v, e);
        end
        repeat (40) tick();
        for (int t = chk_from; t <= cyc; t++) begin
            n_checks++;
            if (txlog[t] !== exp_tx(t)) begin
                n_fail++;
                $display("FAIL single_tx t=%0d got %b want %b",
                         t, txlog[t], exp_tx(t));
            end
        end
        chk_from = cyc + 1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] v, e;
        for (int i = 0; i < 4; i++) begin
            store(BASE, 32'h41 + i);
        end
        e = exp_status(cyc);
        read_status(v);
        n_checks++;
        if (v !== e || v[7:4] !== 4'd3 || v[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_status got %h want %h", v, e);
        end
        repeat (4 * (FLEN + 1) + 5) tick();
        for (int t = chk_from; t <= cyc; t++) begin
            n_checks++;
            if (txlog[t] !== exp_tx(t)) begin
                n_fail++;
                $display("FAIL b2b_tx t=%0d got %b want %b",
                         t, txlog[t], exp_tx(t));
            end
        end
        chk_from = cyc + 1;
    endtask

    task automatic test_overflow();
        logic [31:0] v, e;
        for (int i = 0; i < 6; i++) begin
            store(BASE, $urandom);
        end
        e = exp_status(cyc);
        read_status(v);
        n_checks++;
        if (v !== e || v !== 32'h0000_004B) begin
            n_fail++;
            $display("FAIL ovf_status got %h want %h", v, e);
        end
        e = exp_status(cyc);
        read_status(v);
        n_checks++;
        if (v !== e || v[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear got %h want %h", v, e);
        end
        repeat (5 * (FLEN + 1) + 10) tick();
        for (int t = chk_from; t <= cyc; t++) begin
            n_checks++;
            if (txlog[t] !== exp_tx(t)) begin
                n_fail++;
                $display("FAIL ovf_tx t=%0d got %b want %b",
                         t, txlog[t], exp_tx(t));
            end
        end
        chk_from = cyc + 1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        int s;
        store(BASE, 32'h0F);
        store(BASE, $urandom);
        store(BASE, $urandom);
        s = m_start[0];
        while (cyc < s + 1 + 6 * CPB) tick();
        for (int t = chk_from; t <= cyc; t++) begin
            n_checks++;
            if (txlog[t] !== exp_tx(t)) begin
                n_fail++;
                $display("FAIL mid_tx t=%0d got %b want %b",
                         t, txlog[t], exp_tx(t));
            end
        end
        chk_from = cyc + 1;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (tx !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_async got %b want 1", tx);
        end
        model_clear();
        repeat (2) tick();
        reset = 1'b0;
        read_status(v);
        n_checks++;
        if (v !== 32'h0000_0004) begin
            n_fail++;
            $display("FAIL mid_status got %h want 00000004", v);
        end
        repeat (100) tick();
        for (int t = chk_from; t <= cyc; t++) begin
            n_checks++;
            if (txlog[t] !== 1'b1) begin
                n_fail++;
                $display("FAIL post_reset_tx t=%0d got %b want 1",
                         t, txlog[t]);
            end
        end
        chk_from = cyc + 1;
    endtask

    task automatic test_no_hit();
        logic [31:0] v, e;
        address  = 32'h0000_2008;
        mem_read = 1'b1;
        #1;
        n_checks++;
        if (hit !== 1'b0 || output_data !== 32'h0) begin
            n_fail++;
            $display("FAIL miss_read hit=%b data=%h want 0 0",
                     hit, output_data);
        end
        address = BASE;
        #1;
        n_checks++;
        if (hit !== 1'b1 || output_data !== 32'h0) begin
            n_fail++;
            $display("FAIL data_read hit=%b data=%h want 1 0",
                     hit, output_data);
        end
        mem_read   = 1'b0;
        address    = 32'h0000_1FFC;
        input_data = $urandom;
        mem_write  = 1'b1;
        #1;
        n_checks++;
        if (hit !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_write hit=%b want 0", hit);
        end
        tick();
        mem_write = 1'b0;
        store(BASE + 32'd4, $urandom);
        e = exp_status(cyc);
        read_status(v);
        n_checks++;
        if (v !== e || v !== 32'h0000_0004) begin
            n_fail++;
            $display("FAIL nohit_status got %h want %h", v, e);
        end
        repeat (20) tick();
        for (int t = chk_from; t <= cyc; t++) begin
            n_checks++;
            if (txlog[t] !== 1'b1) begin
                n_fail++;
                $display("FAIL nohit_tx t=%0d got %b want 1", t, txlog[t]);
            end
        end
        chk_from = cyc + 1;
    endtask

    task automatic test_random();
        logic [31:0] v, e, a, d;
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 50)) tick();
            a = BASE | 32'($urandom_range(0, 3));
            d = $urandom;
            address    = a;
            input_data = d;
            mem_write  = 1'b1;
            #1;
            n_checks++;
            if (hit !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_hit addr=%h got %b want 1", a, hit);
            end
            tick();
            mem_write = 1'b0;
            model_push(d[7:0], cyc);
            if (i % 2 == 1) begin
                e = exp_status(cyc);
                read_status(v);
                n_checks++;
                if (v !== e) begin
                    n_fail++;
                    $display("FAIL rand_status i=%0d got %h want %h",
                             i, v, e);
                end
            end
        end
        repeat (5 * (FLEN + 1) + 20) tick();
        for (int t = chk_from; t <= cyc; t++) begin
            n_checks++;
            if (txlog[t] !== exp_tx(t)) begin
                n_fail++;
                $display("FAIL rand_tx t=%0d got %b want %b",
                         t, txlog[t], exp_tx(t));
            end
        end
        chk_from = cyc + 1;
    endtask

    initial begin
        reset      = 1'b1;
        address    = '0;
        input_data = '0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_no_hit();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
